alu_issue_arbiter: RTL and testbench

- Shares one registered RV32I ALU datapath (decoder + ALU + output register) between NREQ requesters.
- Requesters present opcode/funct3/funct7/a/b with a valid/ready handshake. A round-robin arbiter issues one operation per cycle to the ALU.
- A tag pipeline tracks the owner of each in-flight op and returns the result with the requester ID.
- A drain FSM stops issue and waits for the pipeline to empty, so the datapath can be safely quiesced or reconfigured.

---
 rtl/alu_issue_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one registered RV32I ALU datapath between NREQ requesters. A
//   round-robin arbiter issues at most one op per cycle. A tag pipe follows
//   each op to its result, and the result is returned with the requester ID.
//   A drain FSM stops issue so that the datapath can be quiesced.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         per-requester handshake (ready is combinational)
//   req_opcode/funct7/funct3      packed op fields, requester i at [w*i +: w]
//   req_a / req_b                 packed 32-bit operands
//   alu_valid, alu_*              registered issue to decoder/ALU
//   alu_result                    ALU output, valid ALU_LAT cycles after alu_valid
//   rsp_valid/rsp_id/rsp_data     one-cycle result pulse with owner ID
//   drain_req / drain_ack         level quiesce request / high while drained
//   busy                          any op in flight
//   stat_grants                   per-requester saturating 16-bit grant counters
//                                 (present only when ALU_ARB_STATS_EN is defined)
module alu_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [7*NREQ-1:0]    req_opcode,
  input  logic [7*NREQ-1:0]    req_funct7,
  input  logic [3*NREQ-1:0]    req_funct3,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 alu_valid,
  output logic [6:0]           alu_opcode,
  output logic [6:0]           alu_funct7,
  output logic [2:0]           alu_funct3,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [31:0]          alu_result,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 drain_req,
  output logic                 drain_ack,
  output logic                 busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]   stat_grants
`endif
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DRAINED} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [ALU_LAT:0] tag_v;
  logic [IDW-1:0]   tag_id [ALU_LAT+1];
  logic             pipe_empty;

  assign pipe_empty = ~alu_valid & ~(|tag_v);
  assign busy       = ~pipe_empty;
  assign drain_ack  = (state == S_DRAINED);

  // Round-robin search starting at rr_ptr; the index wraps by subtraction so
  // non-power-of-two NREQ works.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    if (state == S_RUN) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    for (int unsigned k = 0; k < NREQ; k++)
      req_ready[k] = gnt_any && (gnt_id == IDW'(k));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:     if (drain_req) state_nx = S_DRAIN;
      S_DRAIN:   if (!drain_req) state_nx = S_RUN;
                 else if (pipe_empty) state_nx = S_DRAINED;
      S_DRAINED: if (!drain_req) state_nx = S_RUN;
      default:   state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      rr_ptr     <= '0;
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_funct7 <= '0;
      alu_funct3 <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      tag_v      <= '0;
      for (int unsigned i = 0; i <= ALU_LAT; i++) tag_id[i] <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      state     <= state_nx;
      alu_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr     <= (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
        alu_opcode <= req_opcode[7*int'(gnt_id) +: 7];
        alu_funct7 <= req_funct7[7*int'(gnt_id) +: 7];
        alu_funct3 <= req_funct3[3*int'(gnt_id) +: 3];
        alu_a      <= req_a[32*int'(gnt_id) +: 32];
        alu_b      <= req_b[32*int'(gnt_id) +: 32];
      end
      // Stage 0 loads with alu_valid; the last stage lines up with alu_result.
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int unsigned i = 1; i <= ALU_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      rsp_valid <= tag_v[ALU_LAT];
      if (tag_v[ALU_LAT]) begin
        rsp_id   <= tag_id[ALU_LAT];
        rsp_data <= alu_result;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i] && (stat_grants[16*i +: 16] != '1))
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_opcode, req_funct7;
  logic [5:0]  req_funct3;
  logic [63:0] req_a, req_b;
  logic        alu_valid;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result = '0;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        drain_req, drain_ack, busy;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_grants;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NREQ(2), .ALU_LAT(1), .IDW(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct7(req_funct7), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_funct7(alu_funct7),
    .alu_funct3(alu_funct3), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .drain_req(drain_req), .drain_ack(drain_ack), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  // External registered ALU (ALU_LAT = 1), RV32I R/I-type subset.
  function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [6:0] f7,
                                            input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic alt;
    alt = (op == 7'h33) && f7[5];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clk)
    if (alu_valid) alu_result <= alu_model(alu_opcode, alu_funct7, alu_funct3, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic drn, input logic [6:0] f7,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    req_valid  = vld;
    drain_req  = drn;
    req_opcode = {7'h33, 7'h33};
    req_funct3 = '0;
    req_funct7 = {f7, f7};
    req_a      = {a1, a0};
    req_b      = {b1, b0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic        drn;
    logic [6:0]  f7;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rdy;
    logic        av;
    logic [31:0] aa;
    logic        rv;
    logic        rid;
    logic [31:0] rdata;
    logic        bsy;
    logic        ack;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [1:0] vld, input logic drn, input logic [6:0] f7,
                     input int a0, input int b0, input int a1, input int b1,
                     input logic [1:0] rdy, input logic av, input int aa,
                     input logic rv, input logic rid, input int rdata,
                     input logic bsy, input logic ack);
    vec_t v;
    v.vld = vld; v.drn = drn; v.f7 = f7;
    v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.rdy = rdy; v.av = av; v.aa = aa; v.rv = rv; v.rid = rid; v.rdata = rdata;
    v.bsy = bsy; v.ack = ack;
    tbl.push_back(v);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    drive(2'b00, 1'b0, 7'h00, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    chk("reset_alu_valid", {31'd0, alu_valid}, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_drain_ack", {31'd0, drain_ack}, 0);

    //    vld    drn f7     a0 b0 a1 b1  rdy   av aa  rv id data bsy ack
    // single op
    row(2'b01, 0, 7'h00, 5, 7, 0, 0,   2'b01, 0, 0,  0, 0, 0,  0, 0);
    row(2'b00, 0, 7'h00, 5, 7, 0, 0,   2'b00, 1, 5,  0, 0, 0,  1, 0);
    row(2'b00, 0, 7'h00, 5, 7, 0, 0,   2'b00, 0, 0,  0, 0, 0,  1, 0);
    row(2'b00, 0, 7'h00, 5, 7, 0, 0,   2'b00, 0, 0,  1, 0, 12, 0, 0);
    row(2'b00, 0, 7'h00, 5, 7, 0, 0,   2'b00, 0, 0,  0, 0, 12, 0, 0);
    // hold stability: rr_ptr=1, req0 waits one cycle with stable fields
    row(2'b11, 0, 7'h00, 9, 9, 2, 2,   2'b10, 0, 0,  0, 0, 12, 0, 0);
    row(2'b01, 0, 7'h00, 9, 9, 2, 2,   2'b01, 1, 2,  0, 0, 12, 1, 0);
    // single requester granted every cycle (ADD then SUB)
    row(2'b10, 0, 7'h00, 9, 9, 3, 3,   2'b10, 1, 9,  0, 0, 12, 1, 0);
    row(2'b10, 0, 7'h20, 9, 9, 10, 3,  2'b10, 1, 3,  1, 1, 4,  1, 0);
    // round robin, all valid
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b01, 1, 10, 1, 0, 18, 1, 0);
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b10, 1, 1,  1, 1, 6,  1, 0);
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b01, 1, 2,  1, 1, 7,  1, 0);
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b10, 1, 1,  1, 0, 2,  1, 0);
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b01, 1, 2,  1, 1, 4,  1, 0);
    row(2'b11, 0, 7'h00, 1, 1, 2, 2,   2'b10, 1, 1,  1, 0, 2,  1, 0);
    row(2'b00, 0, 7'h00, 1, 1, 2, 2,   2'b00, 1, 2,  1, 1, 4,  1, 0);
    row(2'b00, 0, 7'h00, 1, 1, 2, 2,   2'b00, 0, 0,  1, 0, 2,  1, 0);
    row(2'b00, 0, 7'h00, 1, 1, 2, 2,   2'b00, 0, 0,  1, 1, 4,  0, 0);
    // drain with three back-to-back ops; drain_req on the third issue cycle
    row(2'b01, 0, 7'h00, 4, 4, 5, 5,   2'b01, 0, 0,  0, 1, 4,  0, 0);
    row(2'b10, 0, 7'h00, 4, 4, 5, 5,   2'b10, 1, 4,  0, 1, 4,  1, 0);
    row(2'b01, 1, 7'h00, 6, 6, 5, 5,   2'b01, 1, 5,  0, 1, 4,  1, 0);
    row(2'b11, 1, 7'h00, 6, 6, 5, 5,   2'b00, 1, 6,  1, 0, 8,  1, 0);
    row(2'b11, 1, 7'h00, 6, 6, 5, 5,   2'b00, 0, 0,  1, 1, 10, 1, 0);
    row(2'b11, 1, 7'h00, 6, 6, 5, 5,   2'b00, 0, 0,  1, 0, 12, 0, 0);
    row(2'b11, 1, 7'h00, 6, 6, 5, 5,   2'b00, 0, 0,  0, 0, 12, 0, 1);
    row(2'b11, 1, 7'h00, 6, 6, 5, 5,   2'b00, 0, 0,  0, 0, 12, 0, 1);
    row(2'b11, 0, 7'h00, 6, 6, 5, 5,   2'b00, 0, 0,  0, 0, 12, 0, 1);
    row(2'b11, 0, 7'h00, 6, 6, 7, 1,   2'b10, 0, 0,  0, 0, 12, 0, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 1, 7,  0, 0, 12, 1, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 0, 0,  0, 0, 12, 1, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 0, 0,  1, 1, 8,  0, 0);
    // drain_req dropped while in DRAIN returns to RUN
    row(2'b11, 1, 7'h00, 6, 6, 7, 1,   2'b01, 0, 0,  0, 1, 8,  0, 0);
    row(2'b11, 0, 7'h00, 6, 6, 7, 1,   2'b00, 1, 6,  0, 1, 8,  1, 0);
    row(2'b10, 0, 7'h00, 6, 6, 7, 1,   2'b10, 0, 0,  0, 1, 8,  1, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 1, 7,  1, 0, 12, 1, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 0, 0,  0, 0, 12, 1, 0);
    row(2'b00, 0, 7'h00, 6, 6, 7, 1,   2'b00, 0, 0,  1, 1, 8,  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].drn, tbl[i].f7, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      #1;
      chk($sformatf("c%0d_req_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].rdy});
      chk($sformatf("c%0d_alu_valid", i), {31'd0, alu_valid}, {31'd0, tbl[i].av});
      if (tbl[i].av) chk($sformatf("c%0d_alu_a", i), alu_a, tbl[i].aa);
      chk($sformatf("c%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].rv});
      chk($sformatf("c%0d_rsp_id", i), {31'd0, rsp_id}, {31'd0, tbl[i].rid});
      chk($sformatf("c%0d_rsp_data", i), rsp_data, tbl[i].rdata);
      chk($sformatf("c%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("c%0d_drain_ack", i), {31'd0, drain_ack}, {31'd0, tbl[i].ack});
      step();
    end

    // Reset mid-flight: SUB issued, rst the following cycle
    drive(2'b01, 1'b0, 7'h20, 10, 3, 0, 0);
    #1;
    chk("rmf_ready", {30'd0, req_ready}, 32'd1);
    step();
    rst = 1'b1;
    drive(2'b00, 1'b0, 7'h00, 0, 0, 0, 0);
    chk("rmf_alu_valid", {31'd0, alu_valid}, 1);
    chk("rmf_alu_funct7", {25'd0, alu_funct7}, 32'h20);
    step();
    rst = 1'b0;
    chk("rmf_post_alu_valid", {31'd0, alu_valid}, 0);
    chk("rmf_post_alu_funct7", {25'd0, alu_funct7}, 0);
    chk("rmf_post_alu_a", alu_a, 0);
    chk("rmf_post_alu_b", alu_b, 0);
    chk("rmf_post_rsp_data", rsp_data, 0);
    chk("rmf_post_busy", {31'd0, busy}, 0);
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      if (rsp_valid) seen++;
      step();
    end
    chk("rmf_no_rsp", seen, 0);

    // next op after reset behaves normally
    drive(2'b01, 1'b0, 7'h00, 5, 7, 0, 0);
    #1;
    chk("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    drive(2'b00, 1'b0, 7'h00, 0, 0, 0, 0);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      if (rsp_valid) begin
        lat = n;
        break;
      end
      step();
    end
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rsp_data", rsp_data, 12);
    chk("post_rst_rsp_id", {31'd0, rsp_id}, 0);

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(2'b01, 1'b0, 7'h00, 1, 1, 0, 0);
    for (int n = 0; n < 70000; n++) step();
    drive(2'b00, 1'b0, 7'h00, 0, 0, 0, 0);
    step();
    chk("stat_req0_sat", {16'd0, stat_grants[15:0]}, 32'h0000FFFF);
    chk("stat_req1_zero", {16'd0, stat_grants[31:16]}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
